fifo_packetizer: RTL

- Drain side of the single-clock show-ahead FIFO: pops words whenever the FIFO is non-empty and the output can take them, and frames them into packets on a valid/ready stream.
- Each packet is 1..MAX_LEN data words followed by one trailer word carrying the word count and a sequence number; m_last marks the trailer.
- Sits between the mitigation data FIFO and the downstream readout/DMA stream.

---
 rtl/fps_pkt_pkg.sv | 31 +++
 rtl/fifo_packetizer.sv | 119 +++++++++++
 2 files changed

// File: rtl/fps_pkt_pkg.sv
// Shared types and trailer-word layout for the FIFO packetizer.
// The trailer builder lives here so any consumer decodes the same field positions.
package fps_pkt_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DATA    = 2'd1,
    S_TRAILER = 2'd2
  } fps_state_e;

  localparam logic [7:0] TRAILER_MARKER = 8'hA5;

  localparam int TRL_W        = 32;
  localparam int TRL_CNT_LSB  = 0;
  localparam int TRL_CNT_W    = 16;
  localparam int TRL_SEQ_LSB  = 16;
  localparam int TRL_SEQ_W    = 8;
  localparam int TRL_MARK_LSB = 24;
  localparam int TRL_MARK_W   = 8;

  function automatic logic [TRL_W-1:0] build_trailer(input logic [TRL_SEQ_W-1:0] seq,
                                                     input logic [TRL_CNT_W-1:0] count);
    logic [TRL_W-1:0] w_word;
    w_word = '0;
    w_word[TRL_MARK_LSB +: TRL_MARK_W] = TRAILER_MARKER;
    w_word[TRL_SEQ_LSB  +: TRL_SEQ_W]  = seq;
    w_word[TRL_CNT_LSB  +: TRL_CNT_W]  = count;
    return w_word;
  endfunction

endpackage

// File: rtl/fifo_packetizer.sv
// Drains a show-ahead FIFO into a valid/ready stream, framing words into packets
// closed by a trailer carrying word count and sequence number.
//
// state     | meaning
// S_IDLE    | no partial packet (count=0); first pop opens one
// S_DATA    | partial packet open; closes on MAX_LEN, flush or idle timeout
// S_TRAILER | no pops; trailer loads into the output register when it is free
module fifo_packetizer
  import fps_pkt_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd,
  input  logic             flush,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic [7:0]       seq
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [15:0]   MAX_LEN_C = 16'(MAX_LEN);
  localparam logic [IW-1:0] TIMEOUT_C = IW'(TIMEOUT);

  fps_state_e r_state, w_state_nxt;

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_last;
  logic [7:0]       r_seq;
  logic [15:0]      r_count;
  logic [IW-1:0]    r_idle;

  logic             w_free;
  logic             w_pop;
  logic             w_load_trailer;
  logic [15:0]      w_count_inc;
  logic [IW-1:0]    w_idle_inc;

  assign w_free      = !r_valid || m_ready;
  assign w_count_inc = r_count + 16'd1;
  assign w_idle_inc  = r_idle + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Flush only matters in S_DATA; a pop in the same cycle is counted before closing.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_pop) w_state_nxt = (w_count_inc == MAX_LEN_C) ? S_TRAILER : S_DATA;
      end
      S_DATA: begin
        if (w_pop) begin
          if ((w_count_inc == MAX_LEN_C) || flush) w_state_nxt = S_TRAILER;
        end else if (flush || (w_idle_inc == TIMEOUT_C)) begin
          w_state_nxt = S_TRAILER;
        end
      end
      S_TRAILER: begin
        if (w_free) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop          = !fifo_empty && w_free && (r_state != S_TRAILER);
    w_load_trailer = (r_state == S_TRAILER) && w_free;
    fifo_rd        = w_pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_seq   <= 8'd0;
      r_count <= 16'd0;
      r_idle  <= '0;
    end else if (w_load_trailer) begin
      r_data  <= WIDTH'(build_trailer(r_seq, r_count));
      r_valid <= 1'b1;
      r_last  <= 1'b1;
      r_seq   <= r_seq + 8'd1;
      r_count <= 16'd0;
      r_idle  <= '0;
    end else if (w_pop) begin
      r_data  <= fifo_dout;
      r_valid <= 1'b1;
      r_last  <= 1'b0;
      r_count <= w_count_inc;
      r_idle  <= '0;
    end else begin
      if (w_free) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
      // Stalled cycles count as idle too; the FIFO keeps filling meanwhile.
      if ((r_state == S_DATA) && (r_idle != TIMEOUT_C)) r_idle <= w_idle_inc;
    end
  end

  assign m_data  = r_data;
  assign m_valid = r_valid;
  assign m_last  = r_last;
  assign seq     = r_seq;

endmodule
